// File: rtl/adder_pkg.sv
// Shared types and helpers for the multi-cycle adder/subtractor.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must hold values 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB for overflow detection.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (w_c[i]),
      .s  (s[i]),
      .co (w_c[i+1])
    );
  end

  assign co    = w_c[CHUNK];
  assign c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder, the ripple element of chunk_adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/multicycle_add_sub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, carry registered between slices,
// valid/ready on both sides, carry/overflow/zero flags latched with the result.
module multicycle_add_sub
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("multicycle_add_sub: WIDTH must be a multiple of CHUNK");
  end

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_flag_carry;
  logic             r_flag_ovf;
  logic             r_flag_zero;
  logic             r_alive;

  logic [CHUNK-1:0] w_slice_sum;
  logic             w_slice_co;
  logic             w_slice_c_msb;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_next;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a     (r_a_sh[CHUNK-1:0]),
    .b     (r_b_sh[CHUNK-1:0]),
    .ci    (r_carry),
    .s     (w_slice_sum),
    .co    (w_slice_co),
    .c_msb (w_slice_c_msb)
  );

  // r_alive keeps in_ready low until the first clock edge after reset is released.
  assign in_ready   = r_alive && (r_state == IDLE);
  assign w_accept   = in_valid && in_ready;
  assign w_last     = (r_cnt == CW'(NCHUNK - 1));
  assign w_sum_next = (r_sum_sh >> CHUNK) | (WIDTH'(w_slice_sum) << (WIDTH - CHUNK));

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_next_state = RUN;
      RUN:     if (w_last)    w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default:                w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_alive <= 1'b1;
    end
  end

  // NOTE: the datapath registers are cleared on reset too, so outputs read zero during reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_sum_sh     <= '0;
      r_carry      <= 1'b0;
      r_cnt        <= '0;
      r_flag_carry <= 1'b0;
      r_flag_ovf   <= 1'b0;
      r_flag_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a_sh  <= in_a;
            r_b_sh  <= in_b ^ {WIDTH{in_sub}};
            r_carry <= in_sub;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_sum_sh <= w_sum_next;
          r_a_sh   <= r_a_sh >> CHUNK;
          r_b_sh   <= r_b_sh >> CHUNK;
          r_carry  <= w_slice_co;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_flag_carry <= w_slice_co;
            r_flag_ovf   <= w_slice_co ^ w_slice_c_msb;
            r_flag_zero  <= ~|w_sum_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid    = (r_state == DONE);
  assign out_sum      = r_sum_sh;
  assign out_carry    = r_flag_carry;
  assign out_overflow = r_flag_ovf;
  assign out_zero     = r_flag_zero;

endmodule

// File: tb/tb_multicycle_add_sub.sv
// Scoreboard bench for multicycle_add_sub at CHUNK = 4, 1 and 16 (WIDTH = 16).
module tb_multicycle_add_sub;

  localparam int NDUT = 3;

  typedef struct packed {
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
    logic        zero;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    exp_t        e;
  } vec_t;

  function automatic int chunk_of(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid     [NDUT];
  logic        in_ready     [NDUT];
  logic [15:0] in_a         [NDUT];
  logic [15:0] in_b         [NDUT];
  logic        in_sub       [NDUT];
  logic        out_valid    [NDUT];
  logic        out_ready    [NDUT];
  logic [15:0] out_sum      [NDUT];
  logic        out_carry    [NDUT];
  logic        out_overflow [NDUT];
  logic        out_zero     [NDUT];

  exp_t q [NDUT][$];
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs [5];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    multicycle_add_sub #(.WIDTH(16), .CHUNK(chunk_of(g))) u_dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid[g]),
      .in_ready     (in_ready[g]),
      .in_a         (in_a[g]),
      .in_b         (in_b[g]),
      .in_sub       (in_sub[g]),
      .out_valid    (out_valid[g]),
      .out_ready    (out_ready[g]),
      .out_sum      (out_sum[g]),
      .out_carry    (out_carry[g]),
      .out_overflow (out_overflow[g]),
      .out_zero     (out_zero[g])
    );

    // Monitor: pops one expectation per result handshake.
    always @(negedge clk) begin
      exp_t e;
      if (!reset && out_valid[g] && out_ready[g]) begin
        if (q[g].size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL c%0d unexpected result: got sum 0x%0h, expected no result", g, out_sum[g]);
        end else begin
          e = q[g].pop_front();
          check($sformatf("c%0d sum", g),      32'(out_sum[g]),      32'(e.sum));
          check($sformatf("c%0d carry", g),    32'(out_carry[g]),    32'(e.carry));
          check($sformatf("c%0d overflow", g), 32'(out_overflow[g]), 32'(e.ovf));
          check($sformatf("c%0d zero", g),     32'(out_zero[g]),     32'(e.zero));
        end
      end
    end
  end

  task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input exp_t e, input bit hold);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[k]) begin
      check($sformatf("c%0d in_ready timeout", k), 32'(in_ready[k]), 32'd1);
      return;
    end
    in_valid[k]  = 1'b1;
    in_a[k]      = a;
    in_b[k]      = b;
    in_sub[k]    = sub;
    out_ready[k] = !hold;
    @(posedge clk);
    q[k].push_back(e);
    #1 in_valid[k] = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!out_valid[k] && n < 40);
    check($sformatf("c%0d latency", k), 32'(n), 32'(16 / chunk_of(k)));
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        in_valid[k] = 1'b1;
        in_a[k]     = 16'h1111;
        in_b[k]     = 16'h2222;
        in_sub[k]   = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("c%0d hold out_valid", k), 32'(out_valid[k]), 32'd1);
        check($sformatf("c%0d hold in_ready", k),  32'(in_ready[k]),  32'd0);
        check($sformatf("c%0d hold sum", k),       32'(out_sum[k]),   32'(e.sum));
      end
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("c%0d post-handshake out_valid", k), 32'(out_valid[k]), 32'd0);
      check($sformatf("c%0d post-handshake in_ready", k),  32'(in_ready[k]),  32'd1);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      in_valid[k]  = 1'b0;
      in_a[k]      = '0;
      in_b[k]      = '0;
      in_sub[k]    = 1'b0;
      out_ready[k] = 1'b1;
    end
    vecs[0] = '{a: 16'h1234, b: 16'h4321, sub: 1'b0, e: '{sum: 16'h5555, carry: 1'b0, ovf: 1'b0, zero: 1'b0}};
    vecs[1] = '{a: 16'hFFFF, b: 16'h0001, sub: 1'b0, e: '{sum: 16'h0000, carry: 1'b1, ovf: 1'b0, zero: 1'b1}};
    vecs[2] = '{a: 16'h7FFF, b: 16'h0001, sub: 1'b0, e: '{sum: 16'h8000, carry: 1'b0, ovf: 1'b1, zero: 1'b0}};
    vecs[3] = '{a: 16'h8000, b: 16'h0001, sub: 1'b1, e: '{sum: 16'h7FFF, carry: 1'b1, ovf: 1'b1, zero: 1'b0}};
    vecs[4] = '{a: 16'h0003, b: 16'h0005, sub: 1'b1, e: '{sum: 16'hFFFE, carry: 1'b0, ovf: 1'b0, zero: 1'b0}};

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("c%0d reset out_valid", k), 32'(out_valid[k]), 32'd0);
      check($sformatf("c%0d reset in_ready", k),  32'(in_ready[k]),  32'd0);
      check($sformatf("c%0d reset sum", k),       32'(out_sum[k]),   32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1 check("c0 in_ready before first clk", 32'(in_ready[0]), 32'd0);
    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++)
      check($sformatf("c%0d in_ready after release", k), 32'(in_ready[k]), 32'd1);

    for (int k = 0; k < NDUT; k++)
      for (int v = 0; v < 5; v++)
        run_op(k, vecs[v].a, vecs[v].b, vecs[v].sub, vecs[v].e, (k == 0) && (v == 4));

    // Abort an operation two cycles into RUN; nothing may reach the output.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_a[0]     = 16'h1234;
    in_b[0]     = 16'h4321;
    in_sub[0]   = 1'b0;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("c0 mid-run reset out_valid", 32'(out_valid[0]), 32'd0);
    check("c0 mid-run reset in_ready",  32'(in_ready[0]),  32'd0);
    check("c0 mid-run reset sum",       32'(out_sum[0]),   32'd0);
    check("c0 mid-run reset carry",     32'(out_carry[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 check("c0 in_ready right after release", 32'(in_ready[0]), 32'd0);
    run_op(0, 16'h0001, 16'h0001, 1'b0, '{sum: 16'h0002, carry: 1'b0, ovf: 1'b0, zero: 1'b0}, 1'b0);

    repeat (5) @(posedge clk);
    for (int k = 0; k < NDUT; k++)
      check($sformatf("c%0d pending expectations", k), 32'(q[k].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
